// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - 256x8 data memory controller with wait states; optional write protect via DMEM_WRPROT_EN
module data_mem_ctrl #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       cmd,
    input  logic [7:0] addr,
    inout  wire  [7:0] data,
    output logic       ready,
    output logic       done,
    output logic       wp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, XFER} state_t;

    state_t     state;
    state_t     next_state;
    logic [2:0] cnt;
    logic       cmd_q;
    logic [7:0] addr_q;
    logic [7:0] wdata_q;
    logic [7:0] rdata_q;
    logic       prot_hit;
    logic [7:0] mem [256];

`ifdef DMEM_WRPROT_EN
    assign prot_hit = (addr_q[7:4] == 4'hF);
`else
    assign prot_hit = 1'b0;
`endif

    assign ready = (state == IDLE);

    // The bus direction follows the live cmd input, not the captured one.
    assign data = cmd ? 8'hzz : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (req) next_state = (WAIT_CYCLES == 0) ? XFER : WAIT;
            WAIT: if (cnt == 3'd1) next_state = XFER;
            XFER: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 3'd0;
            cmd_q   <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            done    <= 1'b0;
            wp_err  <= 1'b0;
        end else begin
            done   <= (state == XFER);
            wp_err <= (state == XFER) && cmd_q && prot_hit;
            if (state == IDLE && req) begin
                cmd_q  <= cmd;
                addr_q <= addr;
                cnt    <= 3'(WAIT_CYCLES);
                if (cmd) wdata_q <= data;
            end
            if (state == WAIT) cnt <= cnt - 3'd1;
            if (state == XFER && !cmd_q) rdata_q <= mem[addr_q];
        end
    end

    // Storage has no reset; an async reset forces IDLE before any XFER edge.
    always_ff @(posedge clk) begin
        if (state == XFER && cmd_q && !prot_hit) mem[addr_q] <= wdata_q;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized self-checking bench for data_mem_ctrl (WAIT_CYCLES 0 and 1)
module tb_data_mem_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_s = 2'b00;
    logic [1:0] cmd_s = 2'b00;
    logic [1:0] drv = 2'b00;
    logic [7:0] addr_s [2];
    logic [7:0] wd [2];
    wire  [7:0] bus0;
    wire  [7:0] bus1;
    logic [1:0] ready_s;
    logic [1:0] done_s;
    logic [1:0] wperr_s;

    int n_chk = 0;
    int n_fail = 0;

`ifdef DMEM_WRPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    logic [7:0] mm [2][256];
    bit         mv [2][256];
    logic [7:0] last_rd [2];

    always #5 clk = ~clk;

    assign bus0 = drv[0] ? wd[0] : 8'hzz;
    assign bus1 = drv[1] ? wd[1] : 8'hzz;

    data_mem_ctrl #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req_s[0]), .cmd(cmd_s[0]), .addr(addr_s[0]),
        .data(bus0), .ready(ready_s[0]), .done(done_s[0]), .wp_err(wperr_s[0])
    );

    data_mem_ctrl #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req_s[1]), .cmd(cmd_s[1]), .addr(addr_s[1]),
        .data(bus1), .ready(ready_s[1]), .done(done_s[1]), .wp_err(wperr_s[1])
    );

    function automatic logic [7:0] bus(input int k);
        return (k == 1) ? bus1 : bus0;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called just after a falling edge; returns at the falling edge of the done cycle.
    task automatic access(input int k, input bit wr, input logic [7:0] a, input logic [7:0] d);
        int         w;
        bit         prot;
        logic [7:0] got;
        w = k;
        check("ready_before_req", ready_s[k], 1);
        req_s[k] = 1'b1; cmd_s[k] = wr; addr_s[k] = a; wd[k] = d; drv[k] = wr;
        @(negedge clk);
        req_s[k] = 1'b0; addr_s[k] = ~a; wd[k] = ~d;
        for (int i = 0; i <= w; i++) begin
            check("ready_low_busy", ready_s[k], 0);
            check("done_low_busy", done_s[k], 0);
            if (!wr) check("rdata_hold", bus(k), last_rd[k]);
            req_s[k] = 1'($urandom % 2);
            addr_s[k] = 8'($urandom);
            @(negedge clk);
            req_s[k] = 1'b0;
        end
        prot = wr && PROT_EN && (a[7:4] == 4'hF);
        check("done_pulse", done_s[k], 1);
        check("ready_at_done", ready_s[k], 1);
        check("wp_err", wperr_s[k], prot);
        if (wr && !prot) begin
            mm[k][a] = d;
            mv[k][a] = 1'b1;
        end
        if (!wr) begin
            got = bus(k);
            if (mv[k][a]) begin
                check("read_data", got, mm[k][a]);
            end else begin
                mm[k][a] = got;
                mv[k][a] = 1'b1;
            end
            last_rd[k] = mm[k][a];
        end
    endtask

    task automatic idle(input int k);
        req_s[k] = 1'b0;
        @(negedge clk);
        check("done_one_cycle", done_s[k], 0);
        check("ready_idle", ready_s[k], 1);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            addr_s[k] = 8'h00;
            wd[k] = 8'h00;
            last_rd[k] = 8'h00;
            for (int j = 0; j < 256; j++) mv[k][j] = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_ready", ready_s[k], 1);
            check("rst_done", done_s[k], 0);
            check("rst_wp_err", wperr_s[k], 0);
            check("rst_data", bus(k), 8'h00);
        end
        rst_n = 1'b1;
        @(negedge clk);

        access(1, 1'b1, 8'h10, 8'h5A);
        access(1, 1'b0, 8'h10, 8'h00);
        idle(1);

        access(0, 1'b1, 8'h01, 8'h11);
        access(0, 1'b0, 8'h01, 8'h00);
        idle(0);

        access(1, 1'b1, 8'h20, 8'h3C);
        idle(1);
        req_s[1] = 1'b1; cmd_s[1] = 1'b1; addr_s[1] = 8'h20; wd[1] = 8'hFF; drv[1] = 1'b1;
        @(negedge clk);
        req_s[1] = 1'b0; cmd_s[1] = 1'b0; drv[1] = 1'b0;
        rst_n = 1'b0;
        #1;
        check("async_rst_ready", ready_s[1], 1);
        check("async_rst_done", done_s[1], 0);
        check("async_rst_data", bus1, 8'h00);
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        @(negedge clk);
        check("rst_no_done", done_s[1], 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_no_done", done_s[1], 0);
        access(1, 1'b0, 8'h20, 8'h00);
        idle(1);

        for (int k = 0; k < 2; k++) begin
            access(k, 1'b0, 8'hF5, 8'h00);
            access(k, 1'b1, 8'hF5, 8'hAA);
            access(k, 1'b0, 8'hF5, 8'h00);
            idle(k);
        end

        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 40; n++) begin
                logic [7:0] a;
                a = (($urandom % 2) != 0) ? 8'hF0 : 8'h30;
                a = a | 8'($urandom % 16);
                access(k, 1'($urandom % 2), a, 8'($urandom));
                if (($urandom % 4) == 0) idle(k);
            end
            idle(k);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, SHALL set the extra access wait states inserted before the transfer; legal range 0..7.
REQ-002 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req  input  1  SHALL be the access request strobe from the memory-interface stage.
REQ-005 cmd  input  1  SHALL select the access type: 0 = read, 1 = write.
REQ-006 addr  input  8  SHALL be the byte address into 256 x 8 storage.
REQ-007 data  inout  8  SHALL be the bidirectional data bus: upstream drives it when cmd = 1, this block drives it when cmd = 0.
REQ-008 ready  output  1  SHALL be high when a new request can be accepted.
REQ-009 done  output  1  SHALL pulse high for one cycle when an accepted access completes.
REQ-010 wp_err  output  1  SHALL pulse with done when a write was blocked by protection (Configuration).

Function
REQ-011 The block SHALL implement FSM states IDLE, WAIT, XFER; ready = (state == IDLE), combinational.
REQ-012 In IDLE, on a rising edge with req = 1, the block SHALL capture cmd, addr and (if cmd = 1) data into internal registers, load the wait counter with WAIT_CYCLES, and go to WAIT (WAIT_CYCLES > 0) or XFER (WAIT_CYCLES = 0).
REQ-013 In WAIT the counter SHALL decrement each edge; the block SHALL move to XFER on the edge where the counter equals 1.
REQ-014 On the XFER edge the block SHALL perform mem[addr_q] <= wdata_q (write) or rdata_q <= mem[addr_q] (read), set done = 1 for the next cycle only, and return to IDLE.
REQ-015 Latency: request accepted at edge N SHALL give done high in the cycle after edge N+WAIT_CYCLES+1; ready SHALL be low from edge N until that same edge.
REQ-016 req SHALL be ignored while ready = 0 (no queuing); changes to cmd/addr/data after acceptance SHALL have no effect on the accepted access.
REQ-017 A req present in the cycle done is high SHALL be accepted (back-to-back, no bubble cycle).
REQ-018 data SHALL be driven with rdata_q whenever cmd = 0 and high-impedance whenever cmd = 1, independent of FSM state.
REQ-019 rdata_q SHALL hold its value until the next completed read.
REQ-020 A read of an address written by the immediately preceding access SHALL return the newly written value.
REQ-021 All 256 addresses SHALL be valid; no out-of-range or wrap condition exists.

Reset
REQ-022 rst_n = 0 SHALL immediately force state IDLE, ready = 1, done = 0, wp_err = 0, rdata_q = 8'h00, counter = 0.
REQ-023 Reset during WAIT or XFER SHALL abort the access with no storage update and no done pulse.
REQ-024 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-025 With macro DMEM_WRPROT_EN defined, writes to 8'hF0..8'hFF SHALL complete with normal timing and done, leave storage unchanged, and pulse wp_err with done.
REQ-026 Without DMEM_WRPROT_EN, all addresses SHALL be writable and wp_err SHALL be constant 0.
REQ-027 Reads SHALL be unaffected by DMEM_WRPROT_EN.

Verification
REQ-028 Reset, then check outputs -> ready = 1, done = 0, wp_err = 0, data = 8'h00 with cmd = 0.
REQ-029 WAIT_CYCLES = 1: write 8'h5A to 8'h10, then read 8'h10 -> done 3 cycles after each acceptance edge (edge N+2), data = 8'h5A.
REQ-030 WAIT_CYCLES = 0: req held high, write 8'h11 to 8'h01 then read 8'h01 -> accepted on consecutive done cycles, read returns 8'h11.
REQ-031 req pulsed during WAIT, and addr changed after acceptance -> extra req ignored, original address accessed.
REQ-032 rst_n asserted during WAIT of write 8'hFF to 8'h20 -> no done pulse, later read of 8'h20 returns its prior content.
REQ-033 Write 8'hAA to 8'hF5 -> with DMEM_WRPROT_EN: wp_err = 1 with done, read returns old value; without: wp_err = 0, read returns 8'hAA.
